execute_stage: RTL

- Second stage of the 2-stage MIPS pipeline, directly downstream of fetch.
- Consumes the fetched instruction and its PC, then decodes, reads and writes the register file, executes ALU ops, accesses data memory and resolves branches and jumps.
- Sends stall and redirect back to fetch.
- Retires at most one instruction per cycle. Multi-cycle multiply is optional.

---
 rtl/mips_pkg.sv | 72 +++++++
 rtl/mips_regfile.sv | 33 +++
 rtl/execute_stage.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings and types for the MIPS execute stage.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
    AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } alu_op_t;

  typedef enum logic {IDLE, MUL_BUSY} exec_state_t;

  // Source of the register writeback value
  typedef enum logic [2:0] {WbAlu, WbMem, WbLink, WbHi, WbLo} wb_sel_t;

  // Shifts take their operand from b (rt) and their amount from shamt.
  function automatic logic [31:0] alu_eval(alu_op_t op, logic [31:0] a, logic [31:0] b,
                                           logic [4:0] shamt);
    logic [31:0] res;
    res = a + b;
    case (op)
      AluAdd:  res = a + b;
      AluSub:  res = a - b;
      AluAnd:  res = a & b;
      AluOr:   res = a | b;
      AluXor:  res = a ^ b;
      AluNor:  res = ~(a | b);
      AluSlt:  res = {31'd0, $signed(a) < $signed(b)};
      AluSltu: res = {31'd0, a < b};
      AluSll:  res = b << shamt;
      AluSrl:  res = b >> shamt;
      AluSra:  res = $signed(b) >>> shamt;
      AluLui:  res = {b[15:0], 16'h0000};
      default: res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired to zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  // Write port; $0 never takes a write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports
  always_comb begin
    rdata_a_o = (raddr_a_i == REG_ZERO) ? 32'd0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == REG_ZERO) ? 32'd0 : regs_q[raddr_b_i];
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 2-stage MIPS pipeline: decode, regfile, ALU, data memory, branches.
// Optional shift-add MULTU/MFHI/MFLO support is built when EXECUTE_MULDIV_EN is defined.
module execute_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  input  logic [31:0] pc_in,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] reg_output,
  output logic [31:0] mem_output,
  output logic        instr_retired,
  output logic        illegal_instr
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, imm_zext, pc_plus4, branch_pc;
  logic [31:0] rs_val, rt_val, alu_b, alu_res, wb_data, jump_pc;
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;
  logic [4:0]  wr_addr;
  logic        wr_req, is_load, is_store, jump, legal, is_multu;
  logic        stall_int, accept, rf_we, mul_done;

  logic        squash_q, squash_d;
  logic        retired_q, illegal_q;
  logic [31:0] reg_output_q, mem_output_q, last_pc_q;

  assign opcode    = instruction[31:26];
  assign rs        = instruction[25:21];
  assign rt        = instruction[20:16];
  assign rd        = instruction[15:11];
  assign shamt     = instruction[10:6];
  assign funct     = instruction[5:0];
  assign imm_sext  = {{16{instruction[15]}}, instruction[15:0]};
  assign imm_zext  = {16'h0000, instruction[15:0]};
  assign pc_plus4  = pc_in + 32'd4;
  assign branch_pc = pc_plus4 + {imm_sext[29:0], 2'b00};

  mips_regfile u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .raddr_a_i (rs),
    .rdata_a_o (rs_val),
    .raddr_b_i (rt),
    .rdata_b_o (rt_val),
    .we_i      (rf_we),
    .waddr_i   (wr_addr),
    .wdata_i   (wb_data)
  );

  // Instruction decode
  always_comb begin
    alu_op   = AluAdd;
    alu_b    = rt_val;
    wr_req   = 1'b0;
    wr_addr  = rd;
    wb_sel   = WbAlu;
    is_load  = 1'b0;
    is_store = 1'b0;
    jump     = 1'b0;
    jump_pc  = pc_plus4;
    legal    = 1'b1;
    is_multu = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wr_req = 1'b1;
        case (funct)
          FN_ADDU: alu_op = AluAdd;
          FN_SUBU: alu_op = AluSub;
          FN_AND:  alu_op = AluAnd;
          FN_OR:   alu_op = AluOr;
          FN_XOR:  alu_op = AluXor;
          FN_NOR:  alu_op = AluNor;
          FN_SLT:  alu_op = AluSlt;
          FN_SLTU: alu_op = AluSltu;
          FN_SLL:  alu_op = AluSll;
          FN_SRL:  alu_op = AluSrl;
          FN_SRA:  alu_op = AluSra;
          FN_JR: begin
            wr_req  = 1'b0;
            jump    = 1'b1;
            jump_pc = rs_val;
          end
`ifdef EXECUTE_MULDIV_EN
          FN_MULTU: begin
            wr_req   = 1'b0;
            is_multu = 1'b1;
          end
          FN_MFHI: wb_sel = WbHi;
          FN_MFLO: wb_sel = WbLo;
`endif
          default: begin
            wr_req = 1'b0;
            legal  = 1'b0;
          end
        endcase
      end
      OP_ADDIU: begin wr_req = 1'b1; wr_addr = rt; alu_b = imm_sext; end
      OP_SLTI:  begin wr_req = 1'b1; wr_addr = rt; alu_b = imm_sext; alu_op = AluSlt; end
      OP_ANDI:  begin wr_req = 1'b1; wr_addr = rt; alu_b = imm_zext; alu_op = AluAnd; end
      OP_ORI:   begin wr_req = 1'b1; wr_addr = rt; alu_b = imm_zext; alu_op = AluOr; end
      OP_XORI:  begin wr_req = 1'b1; wr_addr = rt; alu_b = imm_zext; alu_op = AluXor; end
      OP_LUI:   begin wr_req = 1'b1; wr_addr = rt; alu_b = imm_zext; alu_op = AluLui; end
      OP_LW: begin
        wr_req  = 1'b1;
        wr_addr = rt;
        alu_b   = imm_sext;
        is_load = 1'b1;
        wb_sel  = WbMem;
      end
      OP_SW: begin
        alu_b    = imm_sext;
        is_store = 1'b1;
      end
      OP_BEQ: begin jump = (rs_val == rt_val); jump_pc = branch_pc; end
      OP_BNE: begin jump = (rs_val != rt_val); jump_pc = branch_pc; end
      OP_J: begin
        jump    = 1'b1;
        jump_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
      end
      OP_JAL: begin
        jump    = 1'b1;
        jump_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
        wr_req  = 1'b1;
        wr_addr = REG_RA;
        wb_sel  = WbLink;
      end
      default: legal = 1'b0;
    endcase
  end

  assign alu_res = alu_eval(alu_op, rs_val, alu_b, shamt);

`ifdef EXECUTE_MULDIV_EN
  exec_state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d, mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] mcand_q, mcand_d, acc_q, acc_d;

  assign stall_int = (state_q == MUL_BUSY);

  // Multiplier FSM: one shift-add step per busy cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mul_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && is_multu) begin
          state_d  = MUL_BUSY;
          cnt_d    = 32'd0;
          mcand_d  = {32'd0, rs_val};
          mplier_d = rt_val;
          acc_d    = 64'd0;
        end
      end
      MUL_BUSY: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 32'd1;
        if (cnt_q == MUL_CYCLES - 1) begin
          hi_d     = acc_d[63:32];
          lo_d     = acc_d[31:0];
          state_d  = IDLE;
          mul_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplier state; reset aborts any multiply in flight and clears HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
`else
  logic unused_mul_cycles;
  assign unused_mul_cycles = ^MUL_CYCLES;
  assign stall_int = 1'b0;
  assign mul_done  = 1'b0;
`endif

  // Writeback value selection
  always_comb begin
    wb_data = alu_res;
    case (wb_sel)
      WbMem:  wb_data = dmem_rdata;
      WbLink: wb_data = pc_plus4;
`ifdef EXECUTE_MULDIV_EN
      WbHi:   wb_data = hi_q;
      WbLo:   wb_data = lo_q;
`endif
      default: wb_data = alu_res;
    endcase
  end

  // An instruction executes only when presented, not held by a stall and not squashed
  assign accept         = instr_valid & ~stall_int & ~squash_q & ~rst;
  assign rf_we          = accept & wr_req;
  assign redirect_valid = accept & legal & jump;
  assign redirect_pc    = rst ? RESET_PC : (redirect_valid ? jump_pc : last_pc_q);
  assign dmem_we        = accept & is_store;
  assign dmem_addr      = alu_res;
  assign dmem_wdata     = rt_val;
  assign stall          = stall_int & ~rst;

  // Squash the first instruction fetch presents after a taken redirect
  always_comb begin
    squash_d = squash_q;
    if (instr_valid && !stall_int && squash_q) squash_d = 1'b0;
    else if (redirect_valid) squash_d = 1'b1;
  end

  // Registered retirement outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_q     <= 1'b0;
      retired_q    <= 1'b0;
      illegal_q    <= 1'b0;
      reg_output_q <= '0;
      mem_output_q <= '0;
      last_pc_q    <= RESET_PC;
    end else begin
      squash_q  <= squash_d;
      retired_q <= (accept & ~is_multu) | mul_done;
      illegal_q <= accept & ~legal;
      if (rf_we) reg_output_q <= wb_data;
      if (accept && is_load) mem_output_q <= dmem_rdata;
      if (accept) last_pc_q <= pc_in;
    end
  end

  assign reg_output    = reg_output_q;
  assign mem_output    = mem_output_q;
  assign instr_retired = retired_q;
  assign illegal_instr = illegal_q;

endmodule
